// File: rtl/hy_riscv_pkg.sv
// hy_riscv_pkg: shared definitions for the hy_riscv load/store path.
//   - RV32I load/store funct3 encodings (F3_*)
//   - lsu_state_t: LSU sequencer states
//   - is_legal_f3(): funct3 legality for a load (we=0) or store (we=1)
package hy_riscv_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // Explicit encodings keep the state values identical to the legacy constants.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        DATA = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } lsu_state_t;

    function automatic logic is_legal_f3(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/hy_riscv_lsu_align.sv
// hy_riscv_lsu_align: combinational lane handling for the LSU.
//   funct3       in  3   access size / signedness
//   addr_lo      in  2   byte offset within the word
//   word         in  32  word read from SRAM
//   wdata        in  32  store data (B/H use low 8/16 bits)
//   load_ext     out 32  selected lane, sign/zero-extended
//   store_merged out 32  word with the store lane replaced (full wdata for W)
module hy_riscv_lsu_align
    import hy_riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_ext,
    output logic [31:0] store_merged
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        shamt     = {addr_lo, 3'b000};
        shifted   = word >> shamt;
        byte_lane = shifted[7:0];
        half_lane = shifted[15:0];

        case (funct3)
            F3_B:    load_ext = {{24{byte_lane[7]}}, byte_lane};
            F3_H:    load_ext = {{16{half_lane[15]}}, half_lane};
            F3_BU:   load_ext = {24'h0, byte_lane};
            F3_HU:   load_ext = {16'h0, half_lane};
            default: load_ext = word;
        endcase

        // Halfword stores are aligned, so the same shift serves both sizes.
        case (funct3)
            F3_B:    store_merged = (word & ~(32'h0000_00FF << shamt)) |
                                    ({24'h0, wdata[7:0]} << shamt);
            F3_H:    store_merged = (word & ~(32'h0000_FFFF << shamt)) |
                                    ({16'h0, wdata[15:0]} << shamt);
            default: store_merged = wdata;
        endcase
    end

endmodule

// File: rtl/hy_riscv_lsu.sv
// hy_riscv_lsu: RV32I load/store unit in front of hy_riscv_sram_set
// (1-cycle registered read, word-wide, no byte enables).
//   clk, reset   clock; asynchronous active-high reset
//   req_*        request handshake (ready only in IDLE), store flag, funct3,
//                byte address, store data
//   resp_*       one-cycle completion pulse, extended load data, error flag
//   mem_*        SRAM side: is_memory_out (1=read, 0=write), word index,
//                write value, read value
// Sub-word stores are performed as read-modify-write (RD, DATA, WR).
module hy_riscv_lsu
    import hy_riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned IDX_W = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_is_out,
    output logic [31:0] mem_index,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        bad_f3;
    logic        misaligned;
    logic        out_of_range;
    logic        req_err;
    logic [31:0] load_ext;
    logic [31:0] store_merged;

    always_comb begin
        bad_f3       = !is_legal_f3(req_we, req_funct3);
        misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        out_of_range = (|req_addr[31:IDX_W+2]) ||
                       ({{(32-IDX_W){1'b0}}, req_addr[IDX_W+1:2]} >= DEPTH);
        req_err      = bad_f3 || misaligned || out_of_range;
    end

    hy_riscv_lsu_align u_align (
        .funct3       (f3_q),
        .addr_lo      (addr_q[1:0]),
        .word         (mem_rdata),
        .wdata        (wdata_q),
        .load_ext     (load_ext),
        .store_merged (store_merged)
    );

    // wdata_q doubles as the SRAM write register: it holds req_wdata for SW and
    // is overwritten with the merged word in DATA for SB/SH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            f3_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        if (req_err) begin
                            resp_rdata <= '0;
                            resp_err   <= 1'b1;
                            state      <= RESP;
                        end else if (req_we && (req_funct3 == F3_W)) begin
                            state <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: state <= DATA;
                DATA: begin
                    if (we_q) begin
                        wdata_q <= store_merged;
                        state   <= WR;
                    end else begin
                        resp_rdata <= load_ext;
                        resp_err   <= 1'b0;
                        state      <= RESP;
                    end
                end
                WR: begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                    state      <= RESP;
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        mem_is_out = (state != WR);
        mem_index  = {2'b00, addr_q[31:2]};
        mem_wdata  = wdata_q;
    end

endmodule

// File: tb/tb_hy_riscv_lsu.sv
// Testbench for hy_riscv_lsu with a behavioural 1-cycle-read SRAM.
// Stimulus pushes expected responses into a queue; a monitor pops and
// compares on each resp_valid, also tallying SRAM write cycles.
module tb_hy_riscv_lsu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_is_out;
    logic [31:0] mem_index;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    hy_riscv_lsu #(.DEPTH(1024), .IDX_W(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_is_out (mem_is_out),
        .mem_index  (mem_index),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // SRAM model: writes while is_memory_out=0, registered read every cycle.
    logic [31:0] sram [0:1023];
    initial begin
        for (int i = 0; i < 1024; i++) sram[i] = '0;
        mem_rdata = '0;
    end
    always @(posedge clk) begin
        if (!mem_is_out) sram[mem_index[9:0]] <= mem_wdata;
        mem_rdata <= sram[mem_index[9:0]];
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        err;
        int unsigned cyc;
        int unsigned nwr;
        logic [31:0] widx;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   next_id = 0;

    task automatic check(input bit ok, input string what, input int id,
                         input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s (req %0d): got 0x%08h expected 0x%08h", what, id, act, req);
    endtask

    // Monitor
    int unsigned wr_cnt = 0;
    logic [31:0] wr_idx = '0;
    logic [31:0] wr_dat = '0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) continue;
            if (!mem_is_out) begin
                wr_cnt++;
                wr_idx = mem_index;
                wr_dat = mem_wdata;
            end
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    check(1'b0, "unexpected_resp", -1, resp_rdata, 32'h0);
                end else begin
                    e = sb.pop_front();
                    check(resp_rdata == e.rdata, "rdata", e.id, resp_rdata, e.rdata);
                    check(resp_err == e.err, "err", e.id, {31'h0, resp_err}, {31'h0, e.err});
                    check(cyc == e.cyc, "latency_cycle", e.id, cyc, e.cyc);
                    check(wr_cnt == e.nwr, "write_cycles", e.id, wr_cnt, e.nwr);
                    if (e.nwr != 0) begin
                        check(wr_idx == e.widx, "write_index", e.id, wr_idx, e.widx);
                        check(wr_dat == e.wdata, "write_data", e.id, wr_dat, e.wdata);
                    end
                end
                wr_cnt = 0;
            end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
                e = sb.pop_front();
                check(1'b0, "resp_timeout", e.id, cyc, e.cyc);
                wr_cnt = 0;
            end
        end
    end

    task automatic wait_ready();
        int unsigned w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) check(1'b0, "ready_timeout", next_id, 32'h0, 32'h1);
    endtask

    // Issue one request at a negedge; lat = cycles from accept edge to resp.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                         input int unsigned lat, input int unsigned nwr,
                         input logic [31:0] widx, input logic [31:0] wval);
        int unsigned w = 0;
        exp_t e;
        wait_ready();
        next_id++;
        e.id = next_id; e.rdata = exp_rd; e.err = exp_err; e.cyc = cyc + lat;
        e.nwr = nwr; e.widx = widx; e.wdata = wval;
        sb.push_back(e);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        while (sb.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
    endtask

    initial begin
        // Reset values
        @(negedge clk);
        @(negedge clk);
        check(req_ready == 1'b1, "rst_req_ready", 0, {31'h0, req_ready}, 32'h1);
        check(resp_valid == 1'b0, "rst_resp_valid", 0, {31'h0, resp_valid}, 32'h0);
        check(resp_rdata == 32'h0, "rst_resp_rdata", 0, resp_rdata, 32'h0);
        check(resp_err == 1'b0, "rst_resp_err", 0, {31'h0, resp_err}, 32'h0);
        check(mem_is_out == 1'b1, "rst_mem_is_out", 0, {31'h0, mem_is_out}, 32'h1);
        check(mem_index == 32'h0, "rst_mem_index", 0, mem_index, 32'h0);
        check(mem_wdata == 32'h0, "rst_mem_wdata", 0, mem_wdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        //     we    f3    addr          wdata         exp_rdata     err   lat nwr widx    wdata
        issue(1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,        1'b0, 2, 1, 32'd4,   32'hDEAD_BEEF);
        issue(1'b0, 3'd2, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 3, 0, 32'h0,  32'h0);
        issue(1'b1, 3'd0, 32'h0000_0011, 32'hFFFF_FF55, 32'h0,        1'b0, 4, 1, 32'd4,   32'hDEAD_55EF);
        issue(1'b0, 3'd2, 32'h0000_0010, 32'h0,         32'hDEAD_55EF, 1'b0, 3, 0, 32'h0,  32'h0);
        issue(1'b0, 3'd0, 32'h0000_0013, 32'h0,         32'hFFFF_FFDE, 1'b0, 3, 0, 32'h0,  32'h0);
        issue(1'b0, 3'd4, 32'h0000_0013, 32'h0,         32'h0000_00DE, 1'b0, 3, 0, 32'h0,  32'h0);
        issue(1'b0, 3'd1, 32'h0000_0012, 32'h0,         32'hFFFF_DEAD, 1'b0, 3, 0, 32'h0,  32'h0);
        issue(1'b0, 3'd5, 32'h0000_0012, 32'h0,         32'h0000_DEAD, 1'b0, 3, 0, 32'h0,  32'h0);
        issue(1'b0, 3'd0, 32'h0000_0011, 32'h0,         32'h0000_0055, 1'b0, 3, 0, 32'h0,  32'h0);
        // Errors: misaligned LW, misaligned SH, index 1024, illegal funct3, high address bits, store f3=4
        issue(1'b0, 3'd2, 32'h0000_0011, 32'h0,         32'h0,        1'b1, 1, 0, 32'h0,   32'h0);
        issue(1'b1, 3'd1, 32'h0000_0013, 32'h1234,      32'h0,        1'b1, 1, 0, 32'h0,   32'h0);
        issue(1'b0, 3'd0, 32'h0000_1000, 32'h0,         32'h0,        1'b1, 1, 0, 32'h0,   32'h0);
        issue(1'b0, 3'd3, 32'h0000_0010, 32'h0,         32'h0,        1'b1, 1, 0, 32'h0,   32'h0);
        issue(1'b0, 3'd2, 32'h8000_0010, 32'h0,         32'h0,        1'b1, 1, 0, 32'h0,   32'h0);
        issue(1'b1, 3'd4, 32'h0000_0010, 32'h0,         32'h0,        1'b1, 1, 0, 32'h0,   32'h0);
        // Top legal index
        issue(1'b1, 3'd2, 32'h0000_0FFC, 32'h1234_5678, 32'h0,        1'b0, 2, 1, 32'd1023, 32'h1234_5678);
        issue(1'b0, 3'd2, 32'h0000_0FFC, 32'h0,         32'h1234_5678, 1'b0, 3, 0, 32'h0,  32'h0);
        // Halfword store into upper lane, then read back
        issue(1'b1, 3'd1, 32'h0000_0012, 32'hAAAA_BEEF, 32'h0,        1'b0, 4, 1, 32'd4,   32'hBEEF_55EF);
        issue(1'b0, 3'd1, 32'h0000_0012, 32'h0,         32'hFFFF_BEEF, 1'b0, 3, 0, 32'h0,  32'h0);

        // Reset during the RD of an SB: aborted, no write afterwards.
        wait_ready();
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h0000_0010; req_wdata = 32'h0000_00AA;
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check(req_ready == 1'b1, "abort_req_ready", 99, {31'h0, req_ready}, 32'h1);
        check(resp_valid == 1'b0, "abort_resp_valid", 99, {31'h0, resp_valid}, 32'h0);
        check(mem_is_out == 1'b1, "abort_mem_is_out", 99, {31'h0, mem_is_out}, 32'h1);
        reset = 1'b0;
        @(negedge clk);
        issue(1'b0, 3'd2, 32'h0000_0010, 32'h0,         32'hBEEF_55EF, 1'b0, 3, 0, 32'h0,  32'h0);

        repeat (3) @(negedge clk);
        check(sb.size() == 0, "scoreboard_drained", 0, sb.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
